// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_periph
// Brief    : Bus-mapped 8N1 UART transmitter with TX FIFO and status register
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
   parameter int FIFO_DEPTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        sel_i,
   input  logic        re_i,
   input  logic        we_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        tx_o
);

   localparam int c_AW = $clog2(FIFO_DEPTH);
   localparam int c_BW = $clog2(CLKS_PER_BIT);
   localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);
   localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_DATA  = 2'd2;
   localparam logic [1:0] c_STOP  = 2'd3;

   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;
   logic            r_ovf;

   logic [1:0]      r_state;
   logic [c_BW-1:0] r_baud;
   logic [2:0]      r_bit;
   logic [7:0]      r_shift;
   logic            r_tx;

   logic w_push_req, w_push, w_ovf_set, w_ovf_clr;
   logic w_not_empty, w_baud_end, w_pop, w_busy;
   logic [7:0]  w_head;
   logic [31:0] w_status;
   logic        w_unused_wdata;

   assign w_push_req  = sel_i & we_i & (addr_i == 4'h0);
   assign w_push      = w_push_req & (r_count < c_DEPTH);
   assign w_ovf_set   = w_push_req & ~w_push;
   assign w_ovf_clr   = sel_i & we_i & (addr_i == 4'h4) & wdata_i[3];
   assign w_not_empty = (r_count != '0);
   assign w_baud_end  = (r_baud == c_BAUD_LAST);
   // A byte leaves the FIFO when idle, or at the end of a stop bit for back-to-back frames
   assign w_pop       = w_not_empty & ((r_state == c_IDLE) | ((r_state == c_STOP) & w_baud_end));
   assign w_busy      = (r_state != c_IDLE);
   assign w_head      = r_mem[r_rd_ptr];
   assign w_status    = {19'd0, 5'(r_count), 4'd0, r_ovf, w_busy,
                         (r_count == c_DEPTH), ~w_not_empty};
   assign w_unused_wdata = ^wdata_i[31:8];

   always_comb begin
      rdata_o = '0;
      if (sel_i && re_i && (addr_i == 4'h4)) rdata_o = w_status;
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= wdata_i[7:0];
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
      end
   end

   // r_tx is loaded with the level of the state being entered, so the line is registered
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         r_state <= c_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_pop) begin
                  r_shift <= w_head;
                  r_baud  <= '0;
                  r_state <= c_START;
                  r_tx    <= 1'b0;
               end
            end
            c_START: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_state <= c_DATA;
                  r_tx    <= r_shift[0];
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            c_DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= c_STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                     r_bit   <= r_bit + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            c_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (w_not_empty) begin
                     r_shift <= w_head;
                     r_state <= c_START;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= c_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
         endcase
      end
   end

   assign tx_o = r_tx;

endmodule
`default_nettype wire

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter that acts as a data-bus responder; the CPU is the bus initiator.
- CPU stores to DATA push bytes into a TX FIFO. An independent FSM serialises each byte onto tx_o as 8N1, LSB first.
- CPU loads from STATUS report FIFO and transmitter state, so software can poll before writing.
- Sits on the core data bus next to memory/stdin/stdout. The top level decodes its window and drives sel_i.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..16.
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 2.

Ports:
clk_i  input  1  clock; all state changes on rising edge.
reset_ni  input  1  synchronous active-low reset.
sel_i  input  1  address window selected by top-level decode.
re_i  input  1  bus read enable.
we_i  input  1  bus write enable.
addr_i  input  4  byte offset within window, word aligned.
wdata_i  input  32  bus write data.
rdata_o  output  32  bus read data.
tx_o  output  1  serial line, idles high.

Behaviour:
- Reset: sampled only on a rising edge with reset_ni=0.
  - FIFO empty, rd/wr pointers 0, count 0, overflow 0.
  - FSM IDLE, baud counter 0; tx_o=1 from the next cycle.
  - A frame in progress is abandoned. Its byte and all queued bytes are lost.
- Register map (access requires sel_i=1):
  - 0x0 DATA: write pushes wdata_i[7:0]; reads return 0.
  - 0x4 STATUS: read bit0=empty, bit1=full, bit2=busy (FSM!=IDLE), bit3=overflow, bits[12:8]=count, other bits 0.
  - 0x4 STATUS write: wdata_i[3]=1 clears overflow (W1C); all other bits ignored.
  - 0x8, 0xC: read 0; writes ignored.
- Read timing:
  - rdata_o is combinational from registered state, zero wait states.
  - rdata_o=0 whenever sel_i=0 or re_i=0.
- Write timing: takes effect at the rising edge where sel_i & we_i = 1.
- Simultaneous re_i and we_i: rdata_o shows pre-edge state and the write still occurs.
- Push acceptance:
  - A push is accepted iff count < FIFO_DEPTH before the edge. A pop in the same cycle does not make room.
  - A rejected push leaves the FIFO unchanged and sets overflow. Overflow set on the same edge as a W1C clear stays set.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If count>0, pop head into an 8-bit shift register, baud=0, go START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
  - DATA: tx_o=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit. After bit 7, go STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. At the end, if count>0, pop and go directly to START (no idle gap); else go IDLE.
- tx_o is registered (glitch-free). Each frame holds tx_o low for exactly CLKS_PER_BIT cycles in START.
- Latency:
  - DATA write at edge N gives count=1 after N.
  - IDLE pops at edge N+1; tx_o falls after N+1.
  - Frame length is 10*CLKS_PER_BIT cycles.
- busy is deasserted only in IDLE. Software drain check: empty=1 and busy=0.

Test Plan:
- Reset then idle 50 cycles, CLKS_PER_BIT=4 -> tx_o=1 throughout; STATUS read = 0x0000_0001.
- Write DATA=0x0000_00A5 at edge N -> tx_o=0 for cycles N+2..N+5; then bits 1,0,1,0,0,1,0,1 for 4 cycles each; stop high for 4 cycles; busy=1 during the frame, 0 after.
- Burst 3 writes 0x31,0x32,0x33 back to back -> three frames with no idle cycle between STOP and the next START; final STATUS=0x0000_0001.
- With tx held in a long frame, write 9 bytes into an 8-deep FIFO -> with pop active, count peaks at 8, full=1 and overflow=1; write STATUS 0x8 -> overflow=0; the 9th byte is never transmitted.
- Assert reset_ni=0 for one cycle mid-DATA of 0xFF with 2 bytes queued -> tx_o=1 after that edge; STATUS=0x1; no further frames.
- Access with sel_i=0, and read/write offset 0x8 with sel_i=1 -> rdata_o=0, FIFO and overflow unchanged, tx_o stays 1.
